uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one 8N1 UART transmit line between two byte
// requesters (0 = CPU UART, 1 = debug/boot monitor).
//
// Ports
//   clk            single clock, rising edge
//   reset          asynchronous, active-low
//   req0_data/valid/ready   requester 0 byte handshake
//   req1_data/valid/ready   requester 1 byte handshake
//   tx             serial line, idle high
//   busy           a frame is in progress
//   owner          requester whose byte is (or last was) on the line
//
// A byte is accepted only while idle. With both requesters waiting, the one
// not served last wins, so contention alternates. Each bit lasts DIV cycles;
// one idle cycle separates back-to-back frames.
module uart_tx_arbiter #(
   parameter int unsigned DIV = 868
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] req0_data,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req1_data,
   input  logic       req1_valid,
   output logic       req1_ready,
   output logic       tx,
   output logic       busy,
   output logic       owner
);

   typedef enum logic [0:0] {StIdle, StSend} state_e;

   localparam logic [15:0] BitReload = 16'(DIV - 1);
   localparam logic [3:0]  LastBit   = 4'd9;
   localparam logic [3:0]  StopBit   = 4'd8;

   state_e      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  data_q, data_d;
   logic        tx_q, tx_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic        grant0, grant1;

   // last_q = 1 means requester 1 was served last, so requester 0 wins a tie.
   always_comb begin
      grant0     = req0_valid & (~req1_valid | last_q);
      grant1     = req1_valid & (~req0_valid | ~last_q);
      // Gated by reset so no ready is shown while reset is held low.
      req0_ready = reset & (state_q == StIdle) & grant0;
      req1_ready = reset & (state_q == StIdle) & grant1;
   end

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      tx_d      = tx_q;
      owner_d   = owner_q;
      last_d    = last_q;
      unique case (state_q)
         StIdle: begin
            if (req0_ready || req1_ready) begin
               state_d   = StSend;
               data_d    = req1_ready ? req1_data : req0_data;
               owner_d   = req1_ready;
               last_d    = req1_ready;
               timer_d   = BitReload;
               bit_cnt_d = 4'd0;
               tx_d      = 1'b0;  // start bit
            end
         end
         StSend: begin
            if (timer_q != 16'd0) begin
               timer_d = timer_q - 16'd1;
            end else if (bit_cnt_q == LastBit) begin
               // End of stop bit: line already high, back to idle.
               state_d   = StIdle;
               bit_cnt_d = 4'd0;
               tx_d      = 1'b1;
            end else begin
               // Bit index n+1 carries data bit n (LSB first), index 9 is stop.
               bit_cnt_d = bit_cnt_q + 4'd1;
               timer_d   = BitReload;
               tx_d      = (bit_cnt_q == StopBit) ? 1'b1 : data_q[bit_cnt_q[2:0]];
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         timer_q   <= 16'd0;
         bit_cnt_q <= 4'd0;
         data_q    <= 8'd0;
         tx_q      <= 1'b1;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         tx_q      <= tx_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
      end
   end

   assign tx    = tx_q;
   assign busy  = (state_q == StSend);
   assign owner = owner_q;

endmodule
